aud_recorder_multi: RTL
=======================

// Module: aud_recorder_multi
// PURPOSE
//  Parametrised I2S capture engine feeding the SRAM write path of the audio recorder. Deserialises
//  MSB-first I2S words from the codec ADC and writes them to sequential addresses with a one-cycle strobe.
//  Supports left-only, right-only or interleaved stereo capture, plus wrap or stop-at-end buffering.
//  Reports written length to the player/control FSM.
// PARAMETERS
//  DATA_W  16          sample width in bits (1..32)
//  ADDR_W  20          address width
//  DEPTH   2**ADDR_W   buffer size in words; must be even when stereo is used; 2 <= DEPTH <= 2**ADDR_W
// PORTS
//  i_clk      in   1         codec BCLK; all logic on rising edge
//  i_rst_n    in   1         reset, asynchronous, active-low
//  i_lrc      in   1         ADCLRCK: 0 = left frame, 1 = right frame
//  i_data     in   1         ADCDAT serial bit
//  i_start    in   1         level/pulse: start from IDLE, resume from PAUSED
//  i_pause    in   1         pause request
//  i_stop     in   1         stop request; returns to IDLE
//  i_mode     in   2         0 = left, 1 = right, 2 = stereo, 3 = reserved (treated as left); latched on start from IDLE
//  i_wrap     in   1         1 = wrap at DEPTH, 0 = stop at DEPTH; latched on start from IDLE
//  o_address  out  ADDR_W    address of the word presented with o_wen
//  o_data     out  DATA_W    captured word
//  o_wen      out  1         one-cycle write strobe
//  o_len      out  ADDR_W+1  words written since start, saturating at DEPTH
//  o_busy     out  1         state != IDLE
//  o_full     out  1         high in FULL
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, latched mode = left, latched wrap = 0, shift register cleared.
//  - Framing: lrc_q = i_lrc registered. An edge where lrc_q != i_lrc is the I2S delay bit.
//    The next DATA_W edges sample MSB..LSB of that frame. Bits beyond DATA_W in a frame are ignored.
//  - Selected frame: left (i_lrc = 0), right (i_lrc = 1), or both in stereo.
//  - States:
//    - IDLE: o_address = 0, o_len = 0. i_start -> ARMED.
//    - ARMED: on the delay bit of a selected frame -> CAPTURE. In stereo, only a left frame qualifies.
//    - CAPTURE: shifts bits. On the edge the LSB is sampled, o_data and o_wen are registered, so o_wen
//      is valid the following cycle at the current o_address (latency one cycle after the LSB).
//      The cycle after o_wen, o_address increments and o_len increments (saturating at DEPTH).
//      Non-stereo: after each word -> ARMED. Stereo: left word is written at an even address, right word
//      at the next odd address; CAPTURE continues across the pair, then -> ARMED.
//    - PAUSED: i_start -> ARMED (resync to frame boundary). Address and o_len are held.
//    - FULL: entered after word DEPTH-1 is written with latched wrap = 0. Address is held at DEPTH-1,
//      o_full = 1, o_wen is never asserted. Only i_stop exits.
//  - Wrap: after word DEPTH-1 with latched wrap = 1, o_address -> 0. o_len stays DEPTH.
//  - Priority when asserted together: i_stop > i_pause > i_start. i_pause is ignored in IDLE and FULL.
//  - Pause or stop mid-word: the partial word is discarded and no o_wen is issued.
//    In stereo, if the left word of a pair was written but the right word was not, o_address rolls back
//    to the even address and o_len decrements by 1, so each pair is written whole or overwritten.
//  - A word whose LSB edge coincides with i_pause/i_stop is discarded.
//  - i_stop from any state -> IDLE on the next edge: o_address = 0, o_full = 0, o_len = 0.
//  - Reset deasserted mid-frame: the first partial frame is never captured, because ARMED waits for an edge.
// STRUCTURE
//  - Package aud_pkg: typedef enum rec_state_e {IDLE, ARMED, CAPTURE, PAUSED, FULL} and
//    typedef enum rec_mode_e {MODE_L, MODE_R, MODE_ST}.
//  - Sub-module aud_i2s_deser (parameter DATA_W): lrc edge detect, bit counter, shift register.
//    Outputs: word, word_valid, word_is_right. The top level keeps the FSM, address and length logic.
// TESTING
//  - Mode left, DATA_W = 16, send L = 16'hA5C3 / R = 16'h1234 frames
//    -> o_wen once per frame, o_data = 16'hA5C3, addresses 0, 1, 2.
//  - Stereo, three frame pairs -> writes to addresses 0..5 alternating L/R values; o_len = 6.
//  - DEPTH = 4, wrap = 0, left mode, 5 frames -> 4 writes, o_full = 1, 5th word dropped, o_address = 3.
//    Then i_stop -> IDLE, o_address = 0.
//  - DEPTH = 4, wrap = 1 -> 5th word written at address 0, o_len = 4.
//  - Stereo, i_pause after the left word at address 2 -> o_address = 2, o_len = 2.
//    Then i_start -> next left word rewritten at address 2.
//  - i_stop and i_pause asserted the same cycle mid-word -> IDLE, no o_wen.
//    Async reset mid-word -> all outputs 0 immediately.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types for the audio recorder capture path: FSM states, capture modes
// and the mode decode used when a recording is started.
package aud_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    PAUSED  = 3'd3,
    FULL    = 3'd4
  } rec_state_e;

  typedef enum logic [1:0] {
    MODE_L  = 2'd0,
    MODE_R  = 2'd1,
    MODE_ST = 2'd2
  } rec_mode_e;

  // Bit counter width inside the deserialiser; covers sample widths up to 32.
  localparam int CNT_W = 6;

  // Code 3 is reserved and records the left channel.
  function automatic rec_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_R;
      2'd2:    return MODE_ST;
      default: return MODE_L;
    endcase
  endfunction

endpackage

// File: rtl/aud_i2s_deser.sv
// I2S receive front end: detects ADCLRCK transitions, skips the one-bit I2S
// delay slot, then shifts in DATA_W bits MSB first. word/word_valid are
// combinational on the edge that samples the LSB so the caller can register
// the finished word on that same edge. Bits past DATA_W in a frame are ignored.
module aud_i2s_deser
  import aud_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              lrc,
  input  logic              data,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              word_is_right,
  output logic              frame_start
);

  logic              lrc_q;
  logic              lrc_vld_q;
  logic              side_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;

  // lrc_vld_q blocks a false frame start on the first edge after reset, when
  // lrc_q has not yet seen the real clock level.
  assign frame_start   = lrc_vld_q && (lrc != lrc_q);
  assign word_valid    = !frame_start && (cnt_q == CNT_W'(1));
  assign word          = (shift_q << 1) | DATA_W'(data);
  assign word_is_right = side_q;

  // Frame tracking, remaining-bit counter and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q     <= 1'b0;
      lrc_vld_q <= 1'b0;
      side_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
    end else begin
      lrc_q     <= lrc;
      lrc_vld_q <= 1'b1;
      if (frame_start) begin
        // Delay slot: data on this edge belongs to no word.
        side_q  <= lrc;
        cnt_q   <= CNT_W'(DATA_W);
        shift_q <= '0;
      end else if (cnt_q != '0) begin
        cnt_q   <= cnt_q - CNT_W'(1);
        shift_q <= word;
      end
    end
  end

endmodule

// File: rtl/aud_recorder_multi.sv
// I2S capture engine feeding the recorder SRAM write port. Captures left,
// right or interleaved stereo words to sequential addresses, with wrap or
// stop-at-end buffering, pause/resume and a saturating written-length count.
//
// Write contract: o_wen is a single-cycle strobe with no back-pressure; while
// it is high, o_address and o_data describe one complete word and the sink
// must accept it that cycle. o_address/o_len advance on the edge ending it.
module aud_recorder_multi
  import aud_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic              i_wrap,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wen,
  output logic [ADDR_W:0]   o_len,
  output logic              o_busy,
  output logic              o_full,
  output logic [2:0]        o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W+1)'(DEPTH);

  rec_state_e state_q, state_d;
  rec_mode_e  mode_q;
  logic       wrap_q;
  logic       half_q;    // stereo: left word taken, right word still owed
  logic       bumped_q;  // last address advance also incremented o_len

  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic              word_is_right;
  logic              frame_start;

  logic exp_right, pair_done, word_accept, frame_sel;
  logic abort, pause_req, drop_pair, full_hit;

  aud_i2s_deser #(.DATA_W(DATA_W)) u_deser (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .lrc          (i_lrc),
    .data         (i_data),
    .word         (word),
    .word_valid   (word_valid),
    .word_is_right(word_is_right),
    .frame_start  (frame_start)
  );

  // Qualifiers shared by the FSM and the address/length datapath.
  always_comb begin
    exp_right   = (mode_q == MODE_R) || ((mode_q == MODE_ST) && half_q);
    pair_done   = (mode_q != MODE_ST) || half_q;
    // A word finishing on the same edge as pause/stop is dropped.
    word_accept = (state_q == CAPTURE) && word_valid &&
                  (word_is_right == exp_right) && !i_pause && !i_stop;
    // Stereo arms only on a left frame so pairs start at even addresses.
    frame_sel   = frame_start && (i_lrc == (mode_q == MODE_R));
    // A frame of the wrong side starting mid-capture means the word was lost.
    abort       = (state_q == CAPTURE) && frame_start && (i_lrc != exp_right);
    pause_req   = i_pause && ((state_q == ARMED) || (state_q == CAPTURE));
    drop_pair   = (mode_q == MODE_ST) && half_q && (pause_req || abort);
    full_hit    = o_wen && (o_address == LAST_ADDR) && !wrap_q;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; stop beats everything, end-of-buffer beats pause.
  always_comb begin
    state_d = state_q;
    if (i_stop) begin
      state_d = IDLE;
    end else if (full_hit) begin
      state_d = FULL;
    end else begin
      case (state_q)
        IDLE:    if (i_start) state_d = ARMED;
        ARMED: begin
          if (i_pause)        state_d = PAUSED;
          else if (frame_sel) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (i_pause)                       state_d = PAUSED;
          else if (abort)                    state_d = ARMED;
          else if (word_accept && pair_done) state_d = ARMED;
        end
        PAUSED:  if (i_start) state_d = ARMED;
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    o_busy  = (state_q != IDLE);
    o_full  = (state_q == FULL);
    o_state = state_q;
  end

  // Write strobe, address/length bookkeeping and configuration latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wen     <= 1'b0;
      o_data    <= '0;
      o_address <= '0;
      o_len     <= '0;
      mode_q    <= MODE_L;
      wrap_q    <= 1'b0;
      half_q    <= 1'b0;
      bumped_q  <= 1'b0;
    end else begin
      o_wen <= word_accept;
      if (word_accept) o_data <= word;

      if (i_stop || (state_q == IDLE)) begin
        o_address <= '0;
        o_len     <= '0;
        half_q    <= 1'b0;
        bumped_q  <= 1'b0;
        if (!i_stop && (state_q == IDLE) && i_start) begin
          mode_q <= decode_mode(i_mode);
          wrap_q <= i_wrap;
        end
      end else if (drop_pair) begin
        // Give back the half-written pair so it is overwritten whole later.
        half_q <= 1'b0;
        if (!o_wen) begin
          o_address <= o_address - ADDR_W'(1);
          if (bumped_q) o_len <= o_len - (ADDR_W+1)'(1);
        end
      end else begin
        if (word_accept && (mode_q == MODE_ST)) half_q <= ~half_q;
        if (o_wen) begin
          if (o_address == LAST_ADDR) begin
            if (wrap_q) o_address <= '0;
          end else begin
            o_address <= o_address + ADDR_W'(1);
          end
          if (o_len != LEN_MAX) begin
            o_len    <= o_len + (ADDR_W+1)'(1);
            bumped_q <= 1'b1;
          end else begin
            bumped_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule
